pulse_stretch: RTL and testbench

PULSE_STRETCH -- requirements
Module: pulse_stretch

---
 rtl/pulse_stretch_pkg.sv | 22 ++
 rtl/pulse_stretch_counter.sv | 29 ++
 rtl/pulse_stretch.sv | 110 +++++++++++
 tb/tb_pulse_stretch.sv | 225 ++++++++++++++++++++++
 4 files changed

// File: rtl/pulse_stretch_pkg.sv
// Shared types and constants for the pulse stretcher: state encoding, counter
// width and the default pulse width used when the width input is zero.
package pulse_stretch_pkg;

    localparam int CNT_W           = 32;
    localparam int DEFAULT_WIDTH_C = 10;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ASSERT  = 2'd1,
        HOLDOFF = 2'd2
    } state_t;

    // A requested width of zero falls back to the configured default.
    function automatic logic [CNT_W-1:0] eff_width(
        input logic [CNT_W-1:0] width,
        input logic [CNT_W-1:0] dflt
    );
        return (width == '0) ? dflt : width;
    endfunction

endpackage

// File: rtl/pulse_stretch_counter.sv
// ps_counter: loadable up-counter whose terminal flag is an equality match
// against term_val; shared by the ASSERT and HOLDOFF phases.
module ps_counter
    import pulse_stretch_pkg::*;
(
    input  logic             clk,
    input  logic             arst_n,
    input  logic             load,
    input  logic             inc,
    input  logic [CNT_W-1:0] term_val,
    output logic             term
);

    logic [CNT_W-1:0] cnt;

    // Load always restarts at 1 so that a match against N marks the Nth cycle.
    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            cnt <= '0;
        end else if (load) begin
            cnt <= CNT_W'(1);
        end else if (inc) begin
            cnt <= cnt + CNT_W'(1);
        end
    end

    assign term = (cnt == term_val);

endmodule

// File: rtl/pulse_stretch.sv
// Pulse stretcher: a sampled trig produces a q pulse of a latched width
// followed by an optional hold-off. Define PULSE_STRETCH_RETRIGGER_EN to let
// trig during a pulse restart its width instead of being dropped.
module pulse_stretch
    import pulse_stretch_pkg::*;
#(
    parameter int unsigned DEFAULT_WIDTH = DEFAULT_WIDTH_C
) (
    input  logic             clk,
    input  logic             arst_n,
    input  logic [CNT_W-1:0] width,
    input  logic [CNT_W-1:0] gap,
    input  logic             trig,
    output logic             q,
    output logic             busy,
    output logic             done,
    output logic             drop
);

`ifdef PULSE_STRETCH_RETRIGGER_EN
    localparam bit RETRIG_EN = 1'b1;
`else
    localparam bit RETRIG_EN = 1'b0;
`endif

    state_t           state;
    logic [CNT_W-1:0] w_lat;
    logic [CNT_W-1:0] g_lat;
    logic [CNT_W-1:0] term_val;
    logic             term;
    logic             accept;
    logic             retrig;
    logic             to_holdoff;
    logic             cnt_load;
    logic             cnt_inc;

    assign accept     = (state == IDLE) && trig;
    assign retrig     = RETRIG_EN && (state == ASSERT) && trig;
    assign to_holdoff = (state == ASSERT) && term && (g_lat != '0) && !retrig;

    // The counter restarts on every phase entry and on a retrigger; it only
    // advances while the current phase has not reached its terminal count.
    assign cnt_load = accept || retrig || to_holdoff;
    assign cnt_inc  = (state != IDLE) && !term;
    assign term_val = (state == HOLDOFF) ? g_lat : w_lat;

    ps_counter u_counter (
        .clk      (clk),
        .arst_n   (arst_n),
        .load     (cnt_load),
        .inc      (cnt_inc),
        .term_val (term_val),
        .term     (term)
    );

    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            state <= IDLE;
            q     <= 1'b0;
            busy  <= 1'b0;
            done  <= 1'b0;
            drop  <= 1'b0;
            w_lat <= '0;
            g_lat <= '0;
        end else begin
            done <= 1'b0;
            drop <= 1'b0;
            case (state)
                IDLE: begin
                    if (trig) begin
                        w_lat <= eff_width(width, CNT_W'(DEFAULT_WIDTH));
                        g_lat <= gap;
                        state <= ASSERT;
                        q     <= 1'b1;
                        busy  <= 1'b1;
                    end
                end
                ASSERT: begin
                    if (!retrig) begin
                        drop <= trig;
                        if (term) begin
                            q <= 1'b0;
                            if (g_lat != '0) begin
                                state <= HOLDOFF;
                            end else begin
                                state <= IDLE;
                                busy  <= 1'b0;
                                done  <= 1'b1;
                            end
                        end
                    end
                end
                HOLDOFF: begin
                    drop <= trig;
                    if (term) begin
                        state <= IDLE;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                    end
                end
                default: begin
                    state <= IDLE;
                    q     <= 1'b0;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_pulse_stretch.sv
// Self-checking bench for pulse_stretch: directed scenarios plus random traffic
// compared cycle by cycle against a remaining-cycles reference model.
module tb_pulse_stretch;

`ifdef PULSE_STRETCH_RETRIGGER_EN
    localparam bit RETRIG = 1'b1;
`else
    localparam bit RETRIG = 1'b0;
`endif
    localparam int DW = 10;

    logic        clk = 1'b0;
    logic        arst_n;
    logic [31:0] width;
    logic [31:0] gap;
    logic        trig;
    logic        q;
    logic        busy;
    logic        done;
    logic        drop;

    int n_cmp = 0;
    int n_err = 0;

    // reference model: cycles of high / hold-off time still to come
    longint hi_rem, ho_rem, w_m, g_m;
    logic   e_q, e_busy, e_done, e_drop;

    // observation tallies for scenario-level checks
    int   q_cnt, busy_cnt, done_cnt, drop_cnt;
    int   low_run, last_low_run;
    logic prev_q;

    always #5 clk = ~clk;

    pulse_stretch #(.DEFAULT_WIDTH(DW)) dut (
        .clk    (clk),
        .arst_n (arst_n),
        .width  (width),
        .gap    (gap),
        .trig   (trig),
        .q      (q),
        .busy   (busy),
        .done   (done),
        .drop   (drop)
    );

    task automatic chk(input string tag, input longint obs, input longint exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        hi_rem = 0; ho_rem = 0; w_m = 0; g_m = 0;
        e_q = 1'b0; e_busy = 1'b0; e_done = 1'b0; e_drop = 1'b0;
    endtask

    task automatic model_edge(input logic t, input logic a);
        if (!a) begin
            model_reset();
            return;
        end
        e_done = 1'b0;
        e_drop = 1'b0;
        if (hi_rem > 0) begin
            if (t && RETRIG) begin
                hi_rem = w_m;
            end else begin
                e_drop = t;
                hi_rem--;
                if (hi_rem == 0) begin
                    if (g_m > 0) ho_rem = g_m;
                    else e_done = 1'b1;
                end
            end
        end else if (ho_rem > 0) begin
            e_drop = t;
            ho_rem--;
            if (ho_rem == 0) e_done = 1'b1;
        end else if (t) begin
            w_m    = (width == 0) ? DW : longint'(width);
            g_m    = longint'(gap);
            hi_rem = w_m;
        end
        e_q    = (hi_rem > 0);
        e_busy = (hi_rem > 0) || (ho_rem > 0);
    endtask

    task automatic check_outputs(input string tag);
        chk({tag, ".q"},    q,    e_q);
        chk({tag, ".busy"}, busy, e_busy);
        chk({tag, ".done"}, done, e_done);
        chk({tag, ".drop"}, drop, e_drop);
    endtask

    task automatic clear_counts();
        q_cnt = 0; busy_cnt = 0; done_cnt = 0; drop_cnt = 0;
    endtask

    task automatic cycle(input logic t, input logic a);
        @(negedge clk);
        trig   = t;
        arst_n = a;
        @(posedge clk);
        model_edge(t, a);
        #1;
        check_outputs("cyc");
        if (q === 1'b1) q_cnt++;
        if (busy === 1'b1) busy_cnt++;
        if (done === 1'b1) done_cnt++;
        if (drop === 1'b1) drop_cnt++;
        if (q === 1'b1 && prev_q !== 1'b1) last_low_run = low_run;
        if (q === 1'b1) low_run = 0;
        else low_run++;
        prev_q = q;
    endtask

    task automatic run(input int n, input logic t);
        for (int i = 0; i < n; i++) cycle(t, 1'b1);
    endtask

    initial begin
        arst_n = 1'b0; trig = 1'b0; width = '0; gap = '0;
        model_reset();
        clear_counts();
        low_run = 0; last_low_run = 0; prev_q = 1'b0;
        #2;
        check_outputs("reset");
        @(negedge clk);
        arst_n = 1'b1;

        // width 3, no gap, single trig at cycle 5
        width = 3; gap = 0;
        clear_counts();
        run(5, 1'b0);
        run(1, 1'b1);
        run(8, 1'b0);
        chk("w3.qlen", q_cnt, 3);
        chk("w3.busylen", busy_cnt, 3);
        chk("w3.done", done_cnt, 1);

        // default width with a 2-cycle hold-off
        width = 0; gap = 2;
        clear_counts();
        run(1, 1'b1);
        run(15, 1'b0);
        chk("dflt.qlen", q_cnt, 10);
        chk("dflt.busylen", busy_cnt, 12);
        chk("dflt.done", done_cnt, 1);

        // trig held high: repeated pulses
        width = 4; gap = 3;
        clear_counts();
        run(30, 1'b1);
`ifndef PULSE_STRETCH_RETRIGGER_EN
        chk("held.lowgap", last_low_run, 4);
        chk("held.done", done_cnt, 3);
`endif
        run(40, 1'b0);

        // second trig two cycles into a width-5 pulse
        width = 5; gap = 0;
        clear_counts();
        run(1, 1'b1);
        run(1, 1'b0);
        run(1, 1'b1);
        run(10, 1'b0);
`ifdef PULSE_STRETCH_RETRIGGER_EN
        chk("retrig.qlen", q_cnt, 7);
        chk("retrig.drop", drop_cnt, 0);
`else
        chk("retrig.qlen", q_cnt, 5);
        chk("retrig.drop", drop_cnt, 1);
`endif

        // asynchronous reset three cycles into a width-8 pulse
        width = 8; gap = 0;
        clear_counts();
        run(1, 1'b1);
        run(3, 1'b0);
        #3;
        arst_n = 1'b0;
        #1;
        model_reset();
        check_outputs("arst");
        clear_counts();
        cycle(1'b0, 1'b0);
        cycle(1'b0, 1'b0);
        cycle(1'b1, 1'b1);
        run(12, 1'b0);
        chk("arst.qlen", q_cnt, 8);
        chk("arst.done", done_cnt, 1);

        // width change mid-pulse only affects the next pulse
        width = 4; gap = 0;
        clear_counts();
        run(1, 1'b1);
        run(2, 1'b0);
        width = 9;
        run(5, 1'b0);
        chk("wchg.first", q_cnt, 4);
        clear_counts();
        run(1, 1'b1);
        run(12, 1'b0);
        chk("wchg.second", q_cnt, 9);

        // random traffic with occasional resets
        for (int i = 0; i < 800; i++) begin
            if ($urandom_range(0, 7) == 0) begin
                width = $urandom_range(0, 7);
                gap   = $urandom_range(0, 4);
            end
            if ($urandom_range(0, 199) == 0) cycle(1'b0, 1'b0);
            else cycle(($urandom_range(0, 2) == 0), 1'b1);
        end
        run(25, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
